// File: rtl/pc_source_ctrl.sv
// Next-PC source sequencer: walks one instruction through fetch, decode and the
// branch/jump/jr/exception PC update, pulsing done when the PC is settled.
module pc_source_ctrl #(
   parameter int MEM_LAT = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       step,
   input  logic       dec_valid,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       op_done,
   input  logic       exc_req,
   input  logic [1:0] exc_code,
   output logic [2:0] PCSource,
   output logic       PCWrite,
   output logic       EPCWrite,
   output logic [1:0] exc_cause,
   output logic       busy,
   output logic       done
);

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_DECODE, S_BRANCH, S_JUMP, S_JR,
      S_OTHER, S_EXC_SAVE, S_EXC_WAIT, S_EXC_LOAD, S_DONE
   } state_t;

   localparam logic [3:0] LP_LAT = 4'(MEM_LAT);

   state_t     r_state;
   state_t     w_next;
   logic [3:0] r_cnt;
   logic [1:0] r_exc_cause;
   logic       r_is_bne;
   logic       r_zero;

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // NOTE: w_next gets a default first, so no path through the case infers a latch.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:   if (step) w_next = S_FETCH;
         S_FETCH:  w_next = S_DECODE;
         S_DECODE: begin
            if (dec_valid) begin
               if (exc_req)                                w_next = S_EXC_SAVE;
               else if (opcode == 6'h04 || opcode == 6'h05) w_next = S_BRANCH;
               else if (opcode == 6'h02 || opcode == 6'h03) w_next = S_JUMP;
               else if (opcode == 6'h00 && funct == 6'h08)  w_next = S_JR;
               else                                         w_next = S_OTHER;
            end
         end
         S_BRANCH, S_JUMP, S_JR, S_EXC_LOAD: w_next = S_DONE;
         S_OTHER: begin
            if (exc_req)      w_next = S_EXC_SAVE;
            else if (op_done) w_next = S_DONE;
         end
         S_EXC_SAVE: w_next = S_EXC_WAIT;
         S_EXC_WAIT: if (r_cnt <= 4'd1) w_next = S_EXC_LOAD;
         S_DONE:     w_next = S_IDLE;
         default:    w_next = S_IDLE;
      endcase
   end

   // Branch condition is captured at decode so the BRANCH cycle never looks at live inputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cnt       <= 4'd0;
         r_exc_cause <= 2'd0;
         r_is_bne    <= 1'b0;
         r_zero      <= 1'b0;
      end else begin
         if (r_state == S_DECODE && dec_valid) begin
            r_is_bne <= (opcode == 6'h05);
            r_zero   <= zero;
         end
         if (r_state == S_EXC_SAVE) begin
            r_exc_cause <= exc_code;
            r_cnt       <= LP_LAT;
         end else if (r_state == S_EXC_WAIT) begin
            r_cnt <= r_cnt - 4'd1;
         end
      end
   end

   always_comb begin
      PCSource = 3'd0;
      PCWrite  = 1'b0;
      EPCWrite = 1'b0;
      done     = 1'b0;
      busy     = (r_state != S_IDLE);
      unique case (r_state)
         S_FETCH:    PCWrite = 1'b1;
         S_BRANCH: begin
            PCSource = 3'd1;
            PCWrite  = r_is_bne ? ~r_zero : r_zero;
         end
         S_JUMP:     begin PCSource = 3'd2; PCWrite = 1'b1; end
         S_JR:       begin PCSource = 3'd3; PCWrite = 1'b1; end
         S_EXC_SAVE: EPCWrite = 1'b1;
         S_EXC_LOAD: begin PCSource = 3'd4; PCWrite = 1'b1; end
         S_DONE:     done = 1'b1;
         default:    ;
      endcase
   end

   assign exc_cause = r_exc_cause;

endmodule

// File: tb/tb_pc_source_ctrl.sv
// Directed bench for pc_source_ctrl: per-cycle output vectors
// {PCSource, PCWrite, EPCWrite, busy, done} against hand-derived expectations.
module tb_pc_source_ctrl;

   logic       clk = 1'b0;
   logic       reset, step, dec_valid, zero, op_done, exc_req;
   logic [5:0] opcode, funct;
   logic [1:0] exc_code;
   logic [2:0] PCSource;
   logic       PCWrite, EPCWrite, busy, done;
   logic [1:0] exc_cause;

   int n_cmp = 0;
   int n_err = 0;

   localparam logic [6:0] O_IDLE  = 7'b000_0_0_0_0;
   localparam logic [6:0] O_FETCH = 7'b000_1_0_1_0;
   localparam logic [6:0] O_BUSY  = 7'b000_0_0_1_0;
   localparam logic [6:0] O_BR_T  = 7'b001_1_0_1_0;
   localparam logic [6:0] O_BR_N  = 7'b001_0_0_1_0;
   localparam logic [6:0] O_JUMP  = 7'b010_1_0_1_0;
   localparam logic [6:0] O_JR    = 7'b011_1_0_1_0;
   localparam logic [6:0] O_SAVE  = 7'b000_0_1_1_0;
   localparam logic [6:0] O_LOAD  = 7'b100_1_0_1_0;
   localparam logic [6:0] O_DONE  = 7'b000_0_0_1_1;

   pc_source_ctrl #(.MEM_LAT(3)) dut (
      .clk(clk), .reset(reset), .step(step), .dec_valid(dec_valid),
      .opcode(opcode), .funct(funct), .zero(zero), .op_done(op_done),
      .exc_req(exc_req), .exc_code(exc_code), .PCSource(PCSource),
      .PCWrite(PCWrite), .EPCWrite(EPCWrite), .exc_cause(exc_cause),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] outs();
      return {PCSource, PCWrite, EPCWrite, busy, done};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [6:0] obs;
      reset = 1'b0; step = 1'b1; exc_req = 1'b1; exc_code = 2'd3;
      dec_valid = 1'b1; opcode = 6'h04; funct = 6'h00; zero = 1'b1; op_done = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         obs = outs();
         n_cmp++;
         if (obs !== O_IDLE) begin
            n_err++;
            $display("FAIL reset_outs cyc%0d: got %b want %b", k, obs, O_IDLE);
         end
      end
      n_cmp++;
      if (exc_cause !== 2'd0) begin
         n_err++;
         $display("FAIL reset_cause: got %0d want 0", exc_cause);
      end
      step = 1'b0; exc_req = 1'b0; op_done = 1'b0; exc_code = 2'd0;
      reset = 1'b1;
      tick();
   endtask

   task automatic test_branch();
      logic [5:0] ops  [4] = '{6'h04, 6'h05, 6'h04, 6'h05};
      logic       zs   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      logic [6:0] brv  [4] = '{O_BR_T, O_BR_N, O_BR_N, O_BR_T};
      logic [6:0] exp  [5];
      logic [6:0] obs;
      for (int c = 0; c < 4; c++) begin
         exp = '{O_FETCH, O_BUSY, brv[c], O_DONE, O_IDLE};
         opcode = ops[c]; zero = zs[c]; dec_valid = 1'b1; step = 1'b1;
         for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            step = 1'b0;
            // Flip live zero during BRANCH: outputs must use the decoded copy.
            if (k == 2) zero = ~zero;
            #1;
            obs = outs();
            n_cmp++;
            if (obs !== exp[k]) begin
               n_err++;
               $display("FAIL branch op%0h z%0d cyc%0d: got %b want %b",
                        ops[c], zs[c], k, obs, exp[k]);
            end
         end
      end
   endtask

   task automatic test_jumps();
      logic [5:0] ops [3] = '{6'h00, 6'h03, 6'h02};
      logic [6:0] jv  [3] = '{O_JR, O_JUMP, O_JUMP};
      logic [6:0] exp [5];
      logic [6:0] obs;
      for (int c = 0; c < 3; c++) begin
         exp = '{O_FETCH, O_BUSY, jv[c], O_DONE, O_IDLE};
         opcode = ops[c]; funct = 6'h08; dec_valid = 1'b1; step = 1'b1;
         for (int k = 0; k < 5; k++) begin
            tick();
            step = 1'b0;
            obs = outs();
            n_cmp++;
            if (obs !== exp[k]) begin
               n_err++;
               $display("FAIL jump op%0h cyc%0d: got %b want %b", ops[c], k, obs, exp[k]);
            end
         end
      end
   endtask

   task automatic test_other_exception();
      logic [6:0] pre  [4] = '{O_FETCH, O_BUSY, O_BUSY, O_BUSY};
      logic [6:0] post [7] = '{O_SAVE, O_BUSY, O_BUSY, O_BUSY, O_LOAD, O_DONE, O_IDLE};
      logic [6:0] obs;
      opcode = 6'h00; funct = 6'h20; dec_valid = 1'b1; step = 1'b1;
      exc_req = 1'b0; op_done = 1'b0; exc_code = 2'd0;
      for (int k = 0; k < 4; k++) begin
         tick();
         step = 1'b0;
         obs = outs();
         n_cmp++;
         if (obs !== pre[k]) begin
            n_err++;
            $display("FAIL other_pre cyc%0d: got %b want %b", k, obs, pre[k]);
         end
      end
      exc_req = 1'b1; exc_code = 2'd1; op_done = 1'b1;
      for (int k = 0; k < 7; k++) begin
         tick();
         if (k == 0) begin exc_req = 1'b0; op_done = 1'b0; end
         if (k == 1) exc_code = 2'd2;
         obs = outs();
         n_cmp++;
         if (obs !== post[k]) begin
            n_err++;
            $display("FAIL other_exc cyc%0d: got %b want %b", k, obs, post[k]);
         end
      end
      n_cmp++;
      if (exc_cause !== 2'd1) begin
         n_err++;
         $display("FAIL other_exc_cause: got %0d want 1", exc_cause);
      end
      exc_code = 2'd0;
   endtask

   task automatic test_decode_exception();
      logic [6:0] exp [9] = '{O_FETCH, O_BUSY, O_SAVE, O_BUSY, O_BUSY, O_BUSY,
                              O_LOAD, O_DONE, O_IDLE};
      logic [6:0] obs;
      opcode = 6'h04; zero = 1'b1; dec_valid = 1'b1; exc_req = 1'b1;
      exc_code = 2'd2; step = 1'b1;
      for (int k = 0; k < 9; k++) begin
         tick();
         step = 1'b0;
         if (k == 7) exc_req = 1'b0;
         obs = outs();
         n_cmp++;
         if (obs !== exp[k]) begin
            n_err++;
            $display("FAIL dec_exc cyc%0d: got %b want %b", k, obs, exp[k]);
         end
      end
      n_cmp++;
      if (exc_cause !== 2'd2) begin
         n_err++;
         $display("FAIL dec_exc_cause: got %0d want 2", exc_cause);
      end
   endtask

   task automatic test_reset_mid_wait();
      logic [6:0] pre  [5] = '{O_FETCH, O_BUSY, O_SAVE, O_BUSY, O_BUSY};
      logic [6:0] post [7] = '{O_IDLE, O_IDLE, O_FETCH, O_BUSY, O_JUMP, O_DONE, O_IDLE};
      logic [6:0] obs;
      opcode = 6'h05; dec_valid = 1'b1; exc_req = 1'b1; exc_code = 2'd3; step = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         step = 1'b0;
         obs = outs();
         n_cmp++;
         if (obs !== pre[k]) begin
            n_err++;
            $display("FAIL rst_wait_pre cyc%0d: got %b want %b", k, obs, pre[k]);
         end
      end
      n_cmp++;
      if (exc_cause !== 2'd3) begin
         n_err++;
         $display("FAIL rst_wait_cause_pre: got %0d want 3", exc_cause);
      end
      reset = 1'b0; exc_req = 1'b0; opcode = 6'h02;
      for (int k = 0; k < 7; k++) begin
         tick();
         if (k == 0) reset = 1'b1;
         if (k == 1) step = 1'b1;
         if (k == 2) step = 1'b0;
         obs = outs();
         n_cmp++;
         if (obs !== post[k]) begin
            n_err++;
            $display("FAIL rst_wait_post cyc%0d: got %b want %b", k, obs, post[k]);
         end
         if (k == 0) begin
            n_cmp++;
            if (exc_cause !== 2'd0) begin
               n_err++;
               $display("FAIL rst_wait_cause: got %0d want 0", exc_cause);
            end
         end
      end
   endtask

   task automatic test_step_ignored();
      logic [6:0] exp [10] = '{O_FETCH, O_BUSY, O_BUSY, O_JUMP, O_DONE,
                               O_IDLE, O_IDLE, O_IDLE, O_IDLE, O_IDLE};
      logic [6:0] obs;
      int         n_done = 0;
      opcode = 6'h02; dec_valid = 1'b0; step = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         step = 1'b0;
         if (k == 1) step = 1'b1;
         if (k == 2) dec_valid = 1'b1;
         if (k == 4) step = 1'b1;
         if (done) n_done++;
         obs = outs();
         n_cmp++;
         if (obs !== exp[k]) begin
            n_err++;
            $display("FAIL step_ignored cyc%0d: got %b want %b", k, obs, exp[k]);
         end
      end
      n_cmp++;
      if (n_done !== 1) begin
         n_err++;
         $display("FAIL step_ignored_done_count: got %0d want 1", n_done);
      end
   endtask

   initial begin
      test_reset();
      test_branch();
      test_jumps();
      test_other_exception();
      test_decode_exception();
      test_reset_mid_wait();
      test_step_ignored();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/pc_source_ctrl.md
PC_SOURCE_CTRL -- requirements
Module: pc_source_ctrl

Interface
REQ-001 SHALL have parameter MEM_LAT, default 3, meaning the exception-vector memory read latency in cycles (legal range 1..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 step  input  1  pulse from main control: begin one instruction's PC cycle.
REQ-005 dec_valid  input  1  opcode/funct/zero valid this cycle.
REQ-006 opcode  input  6  instruction opcode.
REQ-007 funct  input  6  R-type function field.
REQ-008 zero  input  1  ALU zero flag for the branch compare.
REQ-009 op_done  input  1  main control: non-PC instruction finished.
REQ-010 exc_req  input  1  exception request (invalid opcode, overflow, divide-by-zero).
REQ-011 exc_code  input  2  cause accompanying exc_req.
REQ-012 PCSource  output  3  next-PC mux select: 0 PC+4, 1 branch target, 2 jump target, 3 register (jr), 4 exception vector.
REQ-013 PCWrite  output  1  PC register load enable.
REQ-014 EPCWrite  output  1  EPC register load enable.
REQ-015 exc_cause  output  2  latched cause of the last exception.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse when the instruction's PC update is complete.

Function
REQ-018 FSM states SHALL be IDLE, FETCH, DECODE, BRANCH, JUMP, JR, OTHER, EXC_SAVE, EXC_WAIT, EXC_LOAD and DONE.
REQ-019 IDLE: all outputs 0 except exc_cause; step=1 -> FETCH.
REQ-020 FETCH (1 cycle): PCSource=0, PCWrite=1; then -> DECODE.
REQ-021 DECODE: hold until dec_valid=1; then apply this priority: exc_req -> EXC_SAVE; opcode 0x04/0x05 -> BRANCH; opcode 0x02/0x03 -> JUMP; opcode 0x00 with funct 0x08 -> JR; otherwise -> OTHER.
REQ-022 BRANCH (1 cycle): PCSource=1; PCWrite=1 iff (opcode 0x04 and zero=1) or (opcode 0x05 and zero=0); opcode and zero are those latched in DECODE.
REQ-023 JUMP (1 cycle): PCSource=2, PCWrite=1. JR (1 cycle): PCSource=3, PCWrite=1. Both then -> DONE.
REQ-024 OTHER: wait; exc_req=1 -> EXC_SAVE; else op_done=1 -> DONE; if both are high in the same cycle, the exception wins.
REQ-025 EXC_SAVE (1 cycle): EPCWrite=1; exc_cause <= exc_code sampled in that cycle; load the 4-bit counter with MEM_LAT; then -> EXC_WAIT.
REQ-026 EXC_WAIT: decrement the counter each cycle, staying exactly MEM_LAT cycles; PCWrite=0; on the cycle the counter reaches 1 -> EXC_LOAD.
REQ-027 EXC_LOAD (1 cycle): PCSource=4, PCWrite=1; then -> DONE.
REQ-028 DONE (1 cycle): done=1, busy=1; then -> IDLE.
REQ-029 PCSource SHALL be 0 in every state not listed above; PCWrite and EPCWrite SHALL be 0 except where stated.
REQ-030 step received while busy=1 SHALL be ignored, not queued.
REQ-031 exc_req outside DECODE and OTHER SHALL be ignored.
REQ-032 All outputs SHALL be registered or decoded from state only, with no combinational path from inputs.
REQ-033 Latency from step to done, with dec_valid and op_done immediate: branch/jump/jr 4 cycles; exception from DECODE MEM_LAT+5 cycles.

Reset
REQ-034 reset=0 at a rising edge SHALL force IDLE, counter=0, exc_cause=0, and PCSource=0, PCWrite=0, EPCWrite=0, busy=0, done=0, in any state including mid-EXC_WAIT.
REQ-035 Reset SHALL take precedence over every other input in the same cycle.

Verification
REQ-036 beq (0x04) with zero=1 after step -> FETCH cycle PCSource=0/PCWrite=1; BRANCH cycle PCSource=1/PCWrite=1; done pulse on the next cycle.
REQ-037 bne (0x05) with zero=1 -> BRANCH cycle PCSource=1, PCWrite=0; done still pulses.
REQ-038 opcode 0x00 funct 0x08 -> one cycle PCSource=3/PCWrite=1; opcode 0x03 -> one cycle PCSource=2/PCWrite=1.
REQ-039 opcode 0x00 funct 0x20, then exc_req=1, exc_code=1 and op_done=1 in the same cycle -> EPCWrite for 1 cycle; 3 cycles with PCWrite=0; then PCSource=4/PCWrite=1; exc_cause=1; done.
REQ-040 reset=0 during the 2nd EXC_WAIT cycle -> next cycle all outputs 0 and busy=0; a subsequent step restarts at FETCH.
REQ-041 step re-pulsed during DECODE -> no effect; exactly one done per accepted step.
